// File: rtl/limn2600_mem_pkg.sv
// Shared encodings for the Limn2600 memory request path: access sizes, controller states and
// the alignment rule applied when a request is accepted.
package limn2600_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_MERGE,
        ST_RESP,
        ST_ERR
    } state_t;

    // Size 3 has no legal alignment, so it is reported through the same path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/limn2600_lane_unit.sv
// Little-endian lane handling between CPU-sized data and SRAM words; purely combinational.
// Extract zero-extends the selected lane of a word; merge overlays the right-justified store data.
module limn2600_lane_unit (
    input  logic [31:0] ext_word,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] ext_dat,
    output logic [31:0] mrg_dat
);
    import limn2600_mem_pkg::*;

    logic [4:0]  shamt;
    logic [31:0] sh;
    logic [31:0] mask;

    always_comb begin
        shamt   = {off, 3'b000};
        sh      = ext_word >> shamt;
        ext_dat = ext_word;
        mask    = '1;
        case (size)
            SZ_BYTE: begin
                ext_dat = {24'h0, sh[7:0]};
                mask    = 32'h0000_00ff << shamt;
            end
            SZ_HALF: begin
                ext_dat = {16'h0, sh[15:0]};
                mask    = 32'h0000_ffff << shamt;
            end
            default: begin
                ext_dat = ext_word;
                mask    = '1;
            end
        endcase
        mrg_dat = (old_word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/limn2600_mem_ctrl.sv
// CPU load/store front end for the word-only Limn2600 SRAM; sub-word stores use read-modify-write.
// Latency 3 cycles (load/word store), 6 (sub-word store), 1 (error); one request in flight, req_ready only in IDLE.
module limn2600_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata
);
    import limn2600_mem_pkg::*;

    state_t          state;
    logic            we_q;
    logic [1:0]      size_q;
    logic [1:0]      off_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rd_word;
    logic            wr_pass;
    logic [TO_W-1:0] cnt;
    logic [31:0]     ext_dat;
    logic [31:0]     mrg_dat;

    limn2600_lane_unit u_lane (
        .ext_word (mem_rdata),
        .size     (size_q),
        .off      (off_q),
        .old_word (rd_word),
        .wdata    (wdata_q),
        .ext_dat  (ext_dat),
        .mrg_dat  (mrg_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            rd_word    <= '0;
            wr_pass    <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        wr_pass   <= 1'b0;
                        req_ready <= 1'b0;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state      <= ST_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            // Sub-word stores start with a read pass, so only word stores write here.
                            state     <= ST_ISSUE;
                            mem_cs    <= 1'b1;
                            mem_we    <= req_we && (req_size == SZ_WORD);
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rdy) begin
                        if (!we_q) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= ext_dat;
                            state      <= ST_RESP;
                        end else if (size_q == SZ_WORD || wr_pass) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else begin
                            rd_word <= mem_rdata;
                            state   <= ST_MERGE;
                        end
                    end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= ST_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_MERGE: begin
                    mem_wdata <= mrg_dat;
                    mem_cs    <= 1'b1;
                    mem_we    <= 1'b1;
                    wr_pass   <= 1'b1;
                    state     <= ST_ISSUE;
                end
                ST_RESP, ST_ERR: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
